// File: rtl/insr_decoder_pipe.sv
// rtl/insr_decoder_pipe.sv - registered RV32I decoder with skid buffer; RV32M decode when RV_M_EXT_EN is defined
module insr_decoder_pipe #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_pc,
   output logic [6:0]         opcode,
   output logic [RADDR_W-1:0] rd,
   output logic [RADDR_W-1:0] rs1,
   output logic [RADDR_W-1:0] rs2,
   output logic [2:0]         funct3,
   output logic [3:0]         alu_action,
   output logic [XLEN-1:0]    imm,
   output logic               rd_we,
   output logic               m_op,
   output logic               illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [6:0]         opcode;
      logic [RADDR_W-1:0] rd;
      logic [RADDR_W-1:0] rs1;
      logic [RADDR_W-1:0] rs2;
      logic [2:0]         funct3;
      logic [3:0]         alu_action;
      logic [XLEN-1:0]    imm;
      logic               rd_we;
      logic               m_op;
      logic               illegal;
   } bundle_t;

   bundle_t         dec;
   bundle_t         out_q;
   bundle_t         skid_q;
   logic            out_valid_q;
   logic            skid_valid;
   logic            accept;
   logic            load_out;
   logic            has_rd;
   logic            ill;
   logic            is_m;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_u;

   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = XLEN'($signed(in_instr[31:20]));
   assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
   assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));

   // Decode the incoming word; fields a format lacks stay zero
   always_comb begin
      dec        = '0;
      has_rd     = 1'b0;
      ill        = 1'b0;
      is_m       = 1'b0;
      dec.pc     = in_pc;
      dec.opcode = in_instr[6:0];
      case (in_instr[6:0])
         OP_R: begin
            has_rd         = 1'b1;
            dec.rs1        = RADDR_W'(in_instr[19:15]);
            dec.rs2        = RADDR_W'(in_instr[24:20]);
            dec.funct3     = f3;
            dec.alu_action = {in_instr[30], f3};
            if (f7 == 7'b0000001) begin
`ifdef RV_M_EXT_EN
               is_m           = 1'b1;
               dec.alu_action = {1'b0, f3};
`else
               ill            = 1'b1;
`endif
            end else if (f7 == 7'b0100000) begin
               ill = !(f3 == 3'b000 || f3 == 3'b101);
            end else if (f7 != 7'b0000000) begin
               ill = 1'b1;
            end
         end
         OP_IMM: begin
            has_rd     = 1'b1;
            dec.rs1    = RADDR_W'(in_instr[19:15]);
            dec.funct3 = f3;
            dec.imm    = imm_i;
            if (f3 == 3'b001) begin
               dec.alu_action = {in_instr[30], f3};
               ill            = (f7 != 7'b0000000);
            end else if (f3 == 3'b101) begin
               dec.alu_action = {in_instr[30], f3};
               ill            = !(f7 == 7'b0000000 || f7 == 7'b0100000);
            end else begin
               dec.alu_action = {1'b0, f3};
            end
         end
         OP_LOAD: begin
            has_rd     = 1'b1;
            dec.rs1    = RADDR_W'(in_instr[19:15]);
            dec.funct3 = f3;
            dec.imm    = imm_i;
            ill        = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
         end
         OP_STORE: begin
            dec.rs1    = RADDR_W'(in_instr[19:15]);
            dec.rs2    = RADDR_W'(in_instr[24:20]);
            dec.funct3 = f3;
            dec.imm    = imm_s;
            ill        = (f3 > 3'b010);
         end
         OP_BRANCH: begin
            dec.rs1    = RADDR_W'(in_instr[19:15]);
            dec.rs2    = RADDR_W'(in_instr[24:20]);
            dec.funct3 = f3;
            dec.imm    = imm_b;
            ill        = (f3 == 3'b010 || f3 == 3'b011);
         end
         OP_LUI, OP_AUIPC: begin
            has_rd  = 1'b1;
            dec.imm = imm_u;
         end
         OP_JAL: begin
            has_rd  = 1'b1;
            dec.imm = imm_j;
         end
         OP_JALR: begin
            has_rd     = 1'b1;
            dec.rs1    = RADDR_W'(in_instr[19:15]);
            dec.funct3 = f3;
            dec.imm    = imm_i;
            ill        = (f3 != 3'b000);
         end
         default: ill = 1'b1;
      endcase
      if (has_rd) dec.rd = RADDR_W'(in_instr[11:7]);
      dec.illegal = ill;
      dec.m_op    = is_m & !ill;
      dec.rd_we   = has_rd & (in_instr[11:7] != 5'd0) & !ill;
   end

   assign in_ready = !skid_valid;
   assign accept   = in_valid & in_ready;
   assign load_out = !out_valid_q | out_ready;

   // Output register plus one-entry skid; flush beats both drain and accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
         out_q       <= '0;
         skid_q      <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_valid  <= 1'b0;
      end else if (load_out) begin
         if (skid_valid) begin
            out_q       <= skid_q;
            out_valid_q <= 1'b1;
            skid_valid  <= 1'b0;
         end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= dec;
         skid_valid <= 1'b1;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pc     = out_q.pc;
   assign opcode     = out_q.opcode;
   assign rd         = out_q.rd;
   assign rs1        = out_q.rs1;
   assign rs2        = out_q.rs2;
   assign funct3     = out_q.funct3;
   assign alu_action = out_q.alu_action;
   assign imm        = out_q.imm;
   assign rd_we      = out_q.rd_we;
   assign m_op       = out_q.m_op;
   assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_insr_decoder_pipe.sv
// tb/tb_insr_decoder_pipe.sv - self-checking bench for insr_decoder_pipe
module tb_insr_decoder_pipe;
   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [6:0]      opcode;
   logic [RW-1:0]   rd, rs1, rs2;
   logic [2:0]      funct3;
   logic [3:0]      alu_action;
   logic [XLEN-1:0] imm;
   logic            rd_we, m_op, illegal;

   insr_decoder_pipe #(.XLEN(XLEN), .RADDR_W(RW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .alu_action(alu_action), .imm(imm), .rd_we(rd_we), .m_op(m_op),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [3:0]  alu;
      logic [31:0] imm;
      logic        we;
      logic        ill;
      logic        m;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      exp_t        e;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } txn_t;

   localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                      7'h37, 7'h17, 7'h6F, 7'h67};

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];
   txn_t q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t dut_bundle();
      exp_t a;
      a.opcode = opcode; a.rd = rd; a.rs1 = rs1; a.rs2 = rs2; a.f3 = funct3;
      a.alu = alu_action; a.imm = imm; a.we = rd_we; a.ill = illegal; a.m = m_op;
      return a;
   endfunction

   task automatic add(input logic [31:0] w, input int r_d, input int r_s1, input int r_s2,
                      input int f, input int alu, input logic [31:0] im,
                      input bit we, input bit ill, input bit m);
      vec_t v;
      v.instr    = w;
      v.e.opcode = w[6:0];
      v.e.rd     = 5'(r_d);
      v.e.rs1    = 5'(r_s1);
      v.e.rs2    = 5'(r_s2);
      v.e.f3     = 3'(f);
      v.e.alu    = 4'(alu);
      v.e.imm    = im;
      v.e.we     = we;
      v.e.ill    = ill;
      v.e.m      = m;
      tbl.push_back(v);
   endtask

   task automatic cmp(input string nm, input exp_t e, input logic [31:0] pc);
      chk({nm, " out_valid"}, out_valid, 1);
      chk({nm, " opcode"}, opcode, e.opcode);
      chk({nm, " rd"}, rd, e.rd);
      chk({nm, " rs1"}, rs1, e.rs1);
      chk({nm, " rs2"}, rs2, e.rs2);
      chk({nm, " funct3"}, funct3, e.f3);
      chk({nm, " alu_action"}, alu_action, e.alu);
      chk({nm, " imm"}, imm, e.imm);
      chk({nm, " rd_we"}, rd_we, e.we);
      chk({nm, " illegal"}, illegal, e.ill);
      chk({nm, " m_op"}, m_op, e.m);
      chk({nm, " out_pc"}, out_pc, pc);
   endtask

   // Reference decode: pick the format from the opcode, then apply that format's field/immediate rules
   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t e;
      int   op, f3, f7, sw, top, simm;
      bit   fr, fi, fs, fb, fu, fj, known, m_enc;
      e  = '0;
      op = int'(w[6:0]);
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      sw = $signed(w);
      fr = (op == 'h33);
      fi = (op == 'h13 || op == 'h03 || op == 'h67);
      fs = (op == 'h23);
      fb = (op == 'h63);
      fu = (op == 'h37 || op == 'h17);
      fj = (op == 'h6F);
      known = fr | fi | fs | fb | fu | fj;
      e.opcode = w[6:0];
      e.ill    = !known;
      if (fr | fi | fu | fj) e.rd  = w[11:7];
      if (fr | fi | fs | fb) e.rs1 = w[19:15];
      if (fr | fs | fb)      e.rs2 = w[24:20];
      if (fr | fi | fs | fb) e.f3  = w[14:12];
      simm = 0;
      if (fi) simm = sw >>> 20;
      if (fs) begin top = sw >>> 25; simm = top * 32 + int'(w[11:7]); end
      if (fb) begin top = sw >>> 31; simm = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2; end
      if (fj) begin top = sw >>> 31; simm = top * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2; end
      if (fu) simm = int'(w & 32'hFFFFF000);
      e.imm = 32'(simm);
      m_enc = fr && f7 == 1;
      if (fr) begin
`ifdef RV_M_EXT_EN
         if (m_enc) e.alu = {1'b0, w[14:12]};
         else       e.alu = {w[30], w[14:12]};
         e.ill = !(f7 == 0 || f7 == 1 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
`else
         e.alu = {w[30], w[14:12]};
         e.ill = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
`endif
      end
      if (op == 'h13) begin
         e.alu = (f3 == 1 || f3 == 5) ? {w[30], w[14:12]} : {1'b0, w[14:12]};
         if (f3 == 1) e.ill = (f7 != 0);
         if (f3 == 5) e.ill = !(f7 == 0 || f7 == 'h20);
      end
      if (op == 'h03) e.ill = (f3 == 3 || f3 == 6 || f3 == 7);
      if (op == 'h67) e.ill = (f3 != 0);
      if (fs) e.ill = (f3 > 2);
      if (fb) e.ill = (f3 == 2 || f3 == 3);
`ifdef RV_M_EXT_EN
      e.m = m_enc && !e.ill;
`else
      e.m = 1'b0;
`endif
      e.we = (fr | fi | fu | fj) && (w[11:7] != 0) && !e.ill;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          pick;
      w    = $urandom;
      pick = $urandom_range(0, 10);
      if (pick < 9) w[6:0] = OPS[pick];
      if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0) begin
         case ($urandom_range(0, 2))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: w[31:25] = 7'h01;
         endcase
      end
      return w;
   endfunction

   initial begin
      logic [31:0] ia, ib, ic;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;

      add(32'hFFF00093, 1, 0, 0, 0, 4'h0, 32'hFFFFFFFF, 1, 0, 0);
      add(32'hFE208EE3, 0, 1, 2, 0, 4'h0, 32'hFFFFFFFC, 0, 0, 0);
      add(32'h123452B7, 5, 0, 0, 0, 4'h0, 32'h12345000, 1, 0, 0);
      add(32'h402081B3, 3, 1, 2, 0, 4'h8, 32'h0, 1, 0, 0);
`ifdef RV_M_EXT_EN
      add(32'h022081B3, 3, 1, 2, 0, 4'h0, 32'h0, 1, 0, 1);
`else
      add(32'h022081B3, 3, 1, 2, 0, 4'h0, 32'h0, 0, 1, 0);
`endif
      add(32'h0000007F, 0, 0, 0, 0, 4'h0, 32'h0, 0, 1, 0);
      add(32'h0020A423, 0, 1, 2, 2, 4'h0, 32'h8, 0, 0, 0);
      add(32'h40335293, 5, 6, 0, 5, 4'hD, 32'h403, 1, 0, 0);
      add(32'hFF9FF06F, 0, 0, 0, 0, 4'h0, 32'hFFFFFFF8, 0, 0, 0);
      add(32'h00013083, 1, 2, 0, 3, 4'h0, 32'h0, 0, 1, 0);
      add(32'h004110E7, 1, 2, 0, 1, 4'h0, 32'h4, 0, 1, 0);
      add(32'hFFFFF397, 7, 0, 0, 0, 4'h0, 32'hFFFFF000, 1, 0, 0);
      add(32'h00000091, 0, 0, 0, 0, 4'h0, 32'h0, 0, 1, 0);
      add(32'h00208033, 0, 1, 2, 0, 4'h0, 32'h0, 0, 0, 0);
      add(32'h40209033, 0, 1, 2, 1, 4'h9, 32'h0, 0, 1, 0);
      add(32'h40109093, 1, 1, 0, 1, 4'h9, 32'h401, 0, 1, 0);

      repeat (2) @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset in_ready", in_ready, 1);
      chk("reset bundle", dut_bundle(), 64'h0);
      chk("reset out_pc", out_pc, 0);
      rst = 1'b0;

      // table vectors, one per cycle with no backpressure
      out_ready = 1'b1;
      foreach (tbl[k]) begin
         in_valid = 1'b1;
         in_instr = tbl[k].instr;
         in_pc    = 32'h100 + 32'(4 * k);
         @(negedge clk);
         cmp($sformatf("vec%0d", k), tbl[k].e, 32'h100 + 32'(4 * k));
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("table drain out_valid", out_valid, 0);

      // backpressure: A, B, C back-to-back with downstream stalled
      ia = 32'hFFF00093; ib = 32'h402081B3; ic = 32'h123452B7;
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = ia; in_pc = 32'h200;
      @(negedge clk);
      chk("bp A in_ready", in_ready, 1);
      cmp("bp A", ref_decode(ia), 32'h200);
      in_instr = ib; in_pc = 32'h204;
      @(negedge clk);
      chk("bp B in_ready", in_ready, 0);
      cmp("bp stall1", ref_decode(ia), 32'h200);
      in_instr = ic; in_pc = 32'h208;
      @(negedge clk);
      chk("bp C held in_ready", in_ready, 0);
      cmp("bp stall2", ref_decode(ia), 32'h200);
      out_ready = 1'b1;
      @(negedge clk);
      cmp("bp B out", ref_decode(ib), 32'h204);
      chk("bp skid drained in_ready", in_ready, 1);
      @(negedge clk);
      cmp("bp C out", ref_decode(ic), 32'h208);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp end out_valid", out_valid, 0);

      // flush with both output and skid full
      out_ready = 1'b0; in_valid = 1'b1; in_instr = ia; in_pc = 32'h300;
      @(negedge clk);
      in_instr = ib; in_pc = 32'h304;
      @(negedge clk);
      chk("fl skid full in_ready", in_ready, 0);
      flush = 1'b1; in_instr = ic; in_pc = 32'h308;
      @(negedge clk);
      chk("fl out_valid", out_valid, 0);
      chk("fl in_ready", in_ready, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("fl after out_valid", out_valid, 0);
      // flush drops the instruction accepted in the same cycle
      in_valid = 1'b1; in_instr = ia; in_pc = 32'h310;
      @(negedge clk);
      cmp("fl D out", ref_decode(ia), 32'h310);
      flush = 1'b1; in_instr = ib; in_pc = 32'h314;
      @(negedge clk);
      chk("fl E dropped1", out_valid, 0);
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("fl E dropped2", out_valid, 0);

      // asynchronous reset while stalled with skid full
      out_ready = 1'b0; in_valid = 1'b1; in_instr = ia; in_pc = 32'h400;
      @(negedge clk);
      in_instr = ib; in_pc = 32'h404;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ar stalled out_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar out_valid", out_valid, 0);
      chk("ar in_ready", in_ready, 1);
      chk("ar bundle", dut_bundle(), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ar after out_valid", out_valid, 0);

      // randomized traffic against a two-slot FIFO model
      for (int c = 0; c < 3000; c++) begin
         bit mv, mr;
         txn_t t;
         mv = q.size() > 0;
         mr = q.size() < 2;
         chk("rnd out_valid", out_valid, mv);
         chk("rnd in_ready", in_ready, mr);
         if (mv) begin
            chk("rnd bundle", dut_bundle(), ref_decode(q[0].instr));
            chk("rnd out_pc", out_pc, q[0].pc);
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 30) == 0);
         in_instr  = rand_instr();
         in_pc     = $urandom & 32'hFFFFFFFC;
         if (flush) begin
            q.delete();
         end else begin
            if (mv && out_ready) void'(q.pop_front());
            if (in_valid && mr) begin
               t.instr = in_instr;
               t.pc    = in_pc;
               q.push_back(t);
            end
         end
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
